// File: rtl/fp_div_pkg.sv
// Shared constants, flag positions and controller states for the sequential binary32 divider.
package fp_div_pkg;

    localparam int FP_N    = 32;
    localparam int FP_NE   = 8;
    localparam int FP_NM   = 23;
    localparam int FP_BIAS = (1 << (FP_NE - 1)) - 1;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam int FLG_INV = 3;
    localparam int FLG_DBZ = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_NORM,
        S_DONE
    } state_e;

endpackage

// File: rtl/fp_unpack.sv
// Splits a float word into sign, exponent, mantissa with hidden bit and class; purely combinational.
// Denormals are treated as zero, so the hidden bit is simply "exponent non-zero".
module fp_unpack #(
    parameter int N  = 32,
    parameter int Ne = 8,
    parameter int Nm = 23
) (
    input  logic [N-1:0]  word_i,
    output logic          sign_o,
    output logic [Ne-1:0] exp_o,
    output logic [Nm:0]   man_o,
    output logic          is_zero_o,
    output logic          is_inf_o,
    output logic          is_nan_o
);

    logic [Nm-1:0] frac;
    logic          exp_max;

    assign sign_o    = word_i[N-1];
    assign exp_o     = word_i[Nm +: Ne];
    assign frac      = word_i[Nm-1:0];
    assign exp_max   = &exp_o;
    assign man_o     = {|exp_o, frac};
    assign is_zero_o = ~|exp_o;
    assign is_inf_o  = exp_max & ~|frac;
    assign is_nan_o  = exp_max & |frac;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential float divider: restoring division, one quotient bit per cycle; 27 cycles normal, 1 cycle special.
// Single operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter int N  = FP_N,
    parameter int Ne = FP_NE,
    parameter int Nm = FP_NM
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] Q,
    output logic [3:0]   flags,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int BIAS = (1 << (Ne - 1)) - 1;
    localparam int EW   = Ne + 2;
    localparam int QW   = Nm + 3;
    localparam logic [N-1:0]         QNAN  = {1'b0, {Ne{1'b1}}, 1'b1, {(Nm-1){1'b0}}};
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << Ne) - 1);

    logic          x_sign, y_sign, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic [Ne-1:0] x_exp, y_exp;
    logic [Nm:0]   x_man, y_man;

    fp_unpack #(.N(N), .Ne(Ne), .Nm(Nm)) u_unpack_x (
        .word_i(X), .sign_o(x_sign), .exp_o(x_exp), .man_o(x_man),
        .is_zero_o(x_zero), .is_inf_o(x_inf), .is_nan_o(x_nan)
    );

    fp_unpack #(.N(N), .Ne(Ne), .Nm(Nm)) u_unpack_y (
        .word_i(Y), .sign_o(y_sign), .exp_o(y_exp), .man_o(y_man),
        .is_zero_o(y_zero), .is_inf_o(y_inf), .is_nan_o(y_nan)
    );

    state_e           state_q;
    logic             sign_q;
    logic [Ne-1:0]    ex_q, ey_q;
    logic [Nm:0]      my_q;
    logic [QW-1:0]    rem_q, quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     q_q;
    logic [3:0]       flags_q;
    logic             in_ready_q, out_valid_q;

    logic         r_sign;
    logic         spc;
    logic [N-1:0] spc_res;
    logic [3:0]   spc_flg;

    assign r_sign = x_sign ^ y_sign;

    // inf/0 is caught by the x_inf arm first, so it yields inf without divbyzero.
    always_comb begin
        spc     = 1'b1;
        spc_res = QNAN;
        spc_flg = '0;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            spc_flg[FLG_INV] = 1'b1;
        end else if (x_inf) begin
            spc_res = {r_sign, {Ne{1'b1}}, {Nm{1'b0}}};
        end else if (y_zero) begin
            spc_res          = {r_sign, {Ne{1'b1}}, {Nm{1'b0}}};
            spc_flg[FLG_DBZ] = 1'b1;
        end else if (x_zero || y_inf) begin
            spc_res = {r_sign, {(N-1){1'b0}}};
        end else begin
            spc     = 1'b0;
            spc_res = '0;
        end
    end

    logic          rem_ge;
    logic [QW-1:0] rem_sub, rem_nxt;

    assign rem_ge  = rem_q >= QW'(my_q);
    assign rem_sub = rem_ge ? rem_q - QW'(my_q) : rem_q;
    assign rem_nxt = rem_sub << 1;

    logic [Nm-1:0]         frac;
    logic                  guard;
    logic [Nm:0]           frac_rnd;
    logic signed [EW-1:0]  e_n;
    logic [N-1:0]          q_d;
    logic [3:0]            flags_d;

    always_comb begin
        e_n = EW'(ex_q) - EW'(ey_q) + EW'(BIAS);
        if (quo_q[QW-1]) begin
            frac  = quo_q[Nm+1:2];
            guard = quo_q[1];
        end else begin
            frac  = quo_q[Nm:1];
            guard = quo_q[0];
            e_n   = e_n - EW'(1);
        end
        frac_rnd = {1'b0, frac} + {{Nm{1'b0}}, guard};
        if (frac_rnd[Nm]) begin
            e_n = e_n + EW'(1);
        end
        flags_d = '0;
        if (e_n >= E_MAX) begin
            q_d              = {sign_q, {Ne{1'b1}}, {Nm{1'b0}}};
            flags_d[FLG_OVF] = 1'b1;
        end else if (e_n[EW-1] || e_n == '0) begin
            q_d              = {sign_q, {(N-1){1'b0}}};
            flags_d[FLG_UNF] = 1'b1;
        end else begin
            q_d = {sign_q, e_n[Ne-1:0], frac_rnd[Nm-1:0]};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            ex_q        <= '0;
            ey_q        <= '0;
            my_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    in_ready_q <= 1'b0;
                    sign_q     <= r_sign;
                    ex_q       <= x_exp;
                    ey_q       <= y_exp;
                    my_q       <= y_man;
                    rem_q      <= QW'(x_man);
                    quo_q      <= '0;
                    cnt_q      <= '0;
                    if (spc) begin
                        q_q         <= spc_res;
                        flags_q     <= spc_flg;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[QW-2:0], rem_ge};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(QW - 1)) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    q_q         <= q_d;
                    flags_q     <= flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed corner cases plus random operands against an integer-arithmetic model.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] X, Y, Q;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    fp_div_seq #(.N(32), .Ne(8), .Nm(23)) dut (
        .clk(clk), .nrst(nrst), .X(X), .Y(Y),
        .in_valid(in_valid), .in_ready(in_ready),
        .Q(Q), .flags(flags), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer quotient of the significands, then the rounding/range rules.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] q, output logic [3:0] f, output bit spc);
        int xe, ye, e;
        longint unsigned mx, my, qq, fr, g;
        bit xz, yz, xi, yi, xn, yn, s;
        xe = int'(x[30:23]);
        ye = int'(y[30:23]);
        xz = (xe == 0);
        yz = (ye == 0);
        xi = (xe == 255) && (x[22:0] == 0);
        yi = (ye == 255) && (y[22:0] == 0);
        xn = (xe == 255) && (x[22:0] != 0);
        yn = (ye == 255) && (y[22:0] != 0);
        s  = x[31] ^ y[31];
        spc = 1'b1;
        f   = 4'b0000;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            q = 32'h7FC00000;
            f = 4'b1000;
        end else if (xi) begin
            q = {s, 8'hFF, 23'h0};
        end else if (yz) begin
            q = {s, 8'hFF, 23'h0};
            f = 4'b0100;
        end else if (xz || yi) begin
            q = {s, 31'h0};
        end else begin
            spc = 1'b0;
            mx  = 64'(8388608) + 64'(x[22:0]);
            my  = 64'(8388608) + 64'(y[22:0]);
            qq  = (mx << 25) / my;
            e   = xe - ye + 127;
            if (qq >= 64'(33554432)) begin
                fr = (qq >> 2) & 64'h7FFFFF;
                g  = (qq >> 1) & 64'h1;
            end else begin
                fr = (qq >> 1) & 64'h7FFFFF;
                g  = qq & 64'h1;
                e  = e - 1;
            end
            fr = fr + g;
            if (fr == 64'(8388608)) begin
                fr = 0;
                e  = e + 1;
            end
            if (e >= 255) begin
                q = {s, 8'hFF, 23'h0};
                f = 4'b0010;
            end else if (e <= 0) begin
                q = {s, 31'h0};
                f = 4'b0001;
            end else begin
                q = {s, 8'(e), 23'(fr)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: v[30:0] = '0;
            1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3: v[30:23] = 8'h00;
            4: v[30:23] = 8'($urandom_range(250, 254));
            5: v[30:23] = 8'($urandom_range(1, 4));
            6: v[22:0] = 23'h7FFFFF;
            default: ;
        endcase
        return v;
    endfunction

    // Leaves the bench #1 after the edge where out_valid rose; lat counts edges after the accepting one.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] q, output logic [3:0] f, output int lat);
        int g;
        @(negedge clk);
        X = x;
        Y = y;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q = Q;
        f = flags;
    endtask

    task automatic release_res();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] eq, input logic [3:0] ef, input int elat);
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
        run_op(x, y, q, f, lat);
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_flags"}, 64'(f), 64'(ef));
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        release_res();
        check({tag, "_vld_drop"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] x, y, eq, hq;
        logic [3:0]  ef, hf;
        bit          spc;
        int          lat;

        nrst      = 1'b0;
        X         = '0;
        Y         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_q", 64'(Q), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        op_check("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
        op_check("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27);
        op_check("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 0);
        op_check("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
        op_check("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27);
        op_check("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27);

        // Consumer stall: result must hold and fresh operands must be ignored.
        run_op(32'h40C00000, 32'h40000000, hq, hf, lat);
        check("hold_first_q", 64'(hq), 64'(32'h40400000));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            X = rand_operand();
            Y = rand_operand();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_q", 64'(Q), 64'(32'h40400000));
            check("hold_flags", 64'(flags), 64'(0));
            check("hold_out_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_res();
        check("rel_out_valid", 64'(out_valid), 64'(0));
        check("rel_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_buffer_vld", 64'(out_valid), 64'(0));
            check("no_buffer_rdy", 64'(in_ready), 64'(1));
        end

        // Reset after ten DIV cycles.
        @(negedge clk);
        X = 32'h40C00000;
        Y = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check("midrst_q", 64'(Q), 64'(0));
        check("midrst_flags", 64'(flags), 64'(0));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_no_result", 64'(out_valid), 64'(0));
        op_check("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);

        for (int i = 0; i < 250; i++) begin
            x = rand_operand();
            y = rand_operand();
            ref_div(x, y, eq, ef, spc);
            op_check($sformatf("rand%0d_%h_%h", i, x, y), x, y, eq, ef, spc ? 0 : 27);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
